never8_sequencer: RTL and testbench

Instruction sequencer for the Never8 core. It is the initiator of the ALU port: it fetches 8-bit instructions from program memory over a req/ack handshake and splits each one into `opcode[7:5]` and `imm[4:0]`. It drives the ALU's `opcode`, `a` and `b` inputs, then commits the returned `data_out`, `zflag` and `c` into the architectural accumulator and flags. It sits between program memory and the `alu8bit` instance at core top level.

---
 rtl/never8_sequencer_pkg.sv | 31 +++
 rtl/never8_sequencer_if.sv | 32 +++
 rtl/never8_sequencer.sv | 144 ++++++++++++++
 tb/tb_never8_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/never8_sequencer_pkg.sv
// Shared definitions for the Never8 instruction sequencer: widths, opcode
// constants, FSM state type and instruction field helpers.
package never8_pkg;

  localparam int INSTR_W = 8;
  localparam int IMM_W   = 5;
  localparam int DATA_W  = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_JNZ = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Opcode field of an instruction word.
  function automatic logic [2:0] opcode_of(input logic [INSTR_W-1:0] ins);
    return ins[7:5];
  endfunction

  // Immediate field of an instruction word.
  function automatic logic [IMM_W-1:0] imm_of(input logic [INSTR_W-1:0] ins);
    return ins[IMM_W-1:0];
  endfunction

endpackage

// File: rtl/never8_sequencer_if.sv
// Bus bundle between the sequencer, program memory and the ALU.
// master = sequencer side, slave = memory/ALU side.
interface never8_sequencer_if #(
  parameter int PC_W = 5
);
  import never8_pkg::*;

  // Program memory fetch handshake
  logic                imem_req;
  logic [PC_W-1:0]     imem_addr;
  logic                imem_ack;
  logic [INSTR_W-1:0]  imem_data;

  // ALU operands and combinational result
  logic [2:0]          alu_opcode;
  logic [IMM_W-1:0]    alu_a;
  logic [DATA_W-1:0]   alu_b;
  logic [DATA_W-1:0]   alu_data;
  logic                alu_zflag;
  logic                alu_c;

  modport master (
    output imem_req, imem_addr, alu_opcode, alu_a, alu_b,
    input  imem_ack, imem_data, alu_data, alu_zflag, alu_c
  );

  modport slave (
    input  imem_req, imem_addr, alu_opcode, alu_a, alu_b,
    output imem_ack, imem_data, alu_data, alu_zflag, alu_c
  );

endinterface

// File: rtl/never8_sequencer.sv
// Never8 instruction sequencer: fetches instructions over a req/ack
// handshake, feeds the external ALU from ir/acc, and commits ALU results
// (or LDI/JNZ effects) into the accumulator, flags and program counter.
module never8_sequencer
  import never8_pkg::*;
#(
  parameter int PC_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  never8_sequencer_if.master bus,
  output logic [DATA_W-1:0]  acc,
  output logic               zf,
  output logic               cf,
  output logic               busy,
  output logic               retired
);

  state_t              r_state;
  logic [PC_W-1:0]     r_pc;
  logic [INSTR_W-1:0]  r_ir;
  logic [DATA_W-1:0]   r_acc;
  logic                r_zf;
  logic                r_cf;

  state_t              w_state_next;
  logic [PC_W-1:0]     w_pc_next;
  logic [INSTR_W-1:0]  w_ir_next;
  logic [DATA_W-1:0]   w_acc_next;
  logic                w_zf_next;
  logic                w_cf_next;
  logic                w_req;
  logic                w_busy;
  logic                w_retired;

  logic [2:0]          w_op;
  logic [IMM_W-1:0]    w_imm;
  logic [PC_W-1:0]     w_imm_pc;
  logic [PC_W-1:0]     w_pc_inc;

  assign w_op     = opcode_of(r_ir);
  assign w_imm    = imm_of(r_ir);
  assign w_imm_pc = PC_W'(w_imm);
  // Natural wrap at the top of the program space.
  assign w_pc_inc = r_pc + PC_W'(1);

  // State and architectural registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_acc   <= '0;
      r_zf    <= 1'b0;
      r_cf    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_ir    <= w_ir_next;
      r_acc   <= w_acc_next;
      r_zf    <= w_zf_next;
      r_cf    <= w_cf_next;
    end
  end

  // Next-state, commit and handshake decode.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ir_next    = r_ir;
    w_acc_next   = r_acc;
    w_zf_next    = r_zf;
    w_cf_next    = r_cf;
    w_req        = 1'b0;
    w_busy       = 1'b0;
    w_retired    = 1'b0;

    case (r_state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          w_state_next = ST_FETCH;
          w_pc_next    = '0;
        end
      end

      ST_FETCH: begin
        w_req  = 1'b1;
        w_busy = 1'b1;
        if (bus.imem_ack) begin
          w_ir_next    = bus.imem_data;
          w_state_next = ST_EXEC;
        end
      end

      ST_EXEC: begin
        w_busy       = 1'b1;
        w_retired    = 1'b1;
        w_state_next = ST_FETCH;
        w_pc_next    = w_pc_inc;
        case (w_op)
          OP_LDI: begin
            // Immediate load bypasses the ALU; carry is left alone.
            w_acc_next = {{(DATA_W-IMM_W){1'b0}}, w_imm};
            w_zf_next  = (w_imm == '0);
          end
          OP_JNZ: begin
            if (!r_zf) begin
              if (w_imm_pc == r_pc) begin
                // Taken branch to itself can never make progress: park.
                w_state_next = ST_HALT;
                w_pc_next    = r_pc;
              end else begin
                w_pc_next = w_imm_pc;
              end
            end
          end
          default: begin
            w_acc_next = bus.alu_data;
            w_zf_next  = bus.alu_zflag;
            w_cf_next  = bus.alu_c;
          end
        endcase
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.imem_req   = w_req;
  assign bus.imem_addr  = r_pc;
  assign bus.alu_opcode = w_op;
  assign bus.alu_a      = w_imm;
  assign bus.alu_b      = r_acc;

  assign acc     = r_acc;
  assign zf      = r_zf;
  assign cf      = r_cf;
  assign busy    = w_busy;
  assign retired = w_retired;

endmodule

// File: tb/tb_never8_sequencer.sv
// Self-checking bench for never8_sequencer: program memory and ALU models,
// an instruction-level reference model with a per-cycle compare process,
// and directed programs with hand-computed results.
module tb_never8_sequencer;
  import never8_pkg::*;

  localparam int PC_W = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] acc;
  logic       zf;
  logic       cf;
  logic       busy;
  logic       retired;

  int checks = 0;
  int errors = 0;

  never8_sequencer_if #(.PC_W(PC_W)) bus ();

  never8_sequencer #(.PC_W(PC_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus),
    .acc     (acc),
    .zf      (zf),
    .cf      (cf),
    .busy    (busy),
    .retired (retired)
  );

  always #5 clk = ~clk;

  // ---------------- environment models ----------------
  logic [7:0] mem [0:31];
  int   ack_mode  = 0;   // 0: ack with req, 1: ack after ack_wait cycles, 2: force_ack
  int   ack_wait  = 3;
  int   wait_cnt  = 0;
  logic force_ack = 1'b0;

  function automatic logic [9:0] alu_fn(input logic [2:0] op, input logic [4:0] a,
                                        input logic [7:0] b);
    logic [8:0] t;
    logic [7:0] d;
    logic       c;
    t = '0; d = '0; c = 1'b0;
    case (op)
      3'b000: begin t = {1'b0, b} + {4'b0, a}; d = t[7:0]; c = t[8]; end
      3'b001: begin t = {1'b0, b} - {4'b0, a}; d = t[7:0]; c = ~t[8]; end
      3'b010: d = b & {3'b0, a};
      3'b011: d = b | {3'b0, a};
      3'b100: d = b ^ {3'b0, a};
      default: begin d = {b[6:0], 1'b0}; c = b[7]; end
    endcase
    return {d, (d == 8'h00), c};
  endfunction

  assign bus.imem_ack  = (ack_mode == 0) ? bus.imem_req :
                         (ack_mode == 1) ? (bus.imem_req && (wait_cnt == ack_wait)) :
                         force_ack;
  assign bus.imem_data = mem[bus.imem_addr];
  assign {bus.alu_data, bus.alu_zflag, bus.alu_c} = alu_fn(bus.alu_opcode, bus.alu_a, bus.alu_b);

  always @(posedge clk) begin
    if (bus.imem_req === 1'b1 && bus.imem_ack !== 1'b1) wait_cnt <= wait_cnt + 1;
    else                                                 wait_cnt <= 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         model_on    = 1'b0;
  bit         m_running   = 1'b0;
  logic [4:0] m_pc        = '0;
  logic [7:0] m_acc       = '0;
  logic       m_zf        = 1'b0;
  logic       m_cf        = 1'b0;
  logic       prev_fetch  = 1'b0;
  int         dut_retires = 0;

  // Execute one instruction at the ISA level.
  task automatic model_step();
    logic [7:0] ins;
    logic [2:0] op;
    logic [4:0] imm;
    logic [9:0] r;
    ins = mem[m_pc];
    op  = ins[7:5];
    imm = ins[4:0];
    if (op == 3'b110) begin
      m_acc = {3'b000, imm};
      m_zf  = (imm == 5'd0);
      m_pc  = m_pc + 5'd1;
    end else if (op == 3'b111) begin
      if (!m_zf) begin
        if (imm == m_pc) m_running = 1'b0;
        else             m_pc = imm;
      end else begin
        m_pc = m_pc + 5'd1;
      end
    end else begin
      r     = alu_fn(op, imm, m_acc);
      m_acc = r[9:2];
      m_zf  = r[1];
      m_cf  = r[0];
      m_pc  = m_pc + 5'd1;
    end
  endtask

  // Per-cycle compare against the model, then advance the model.
  always @(negedge clk) begin
    logic [7:0] ins;
    if (model_on) begin
      check("acc", 32'(acc), 32'(m_acc));
      check("zf", 32'(zf), 32'(m_zf));
      check("cf", 32'(cf), 32'(m_cf));
      check("busy", 32'(busy), 32'(m_running));
      check("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
      check("alu_b", 32'(bus.alu_b), 32'(m_acc));
      if (!m_running) begin
        check("idle_req", 32'(bus.imem_req), 32'd0);
        check("idle_retired", 32'(retired), 32'd0);
      end else begin
        check("retire_after_ack", 32'(retired), 32'(prev_fetch));
        if (retired === 1'b1) begin
          ins = mem[m_pc];
          check("exec_req", 32'(bus.imem_req), 32'd0);
          check("alu_opcode", 32'(bus.alu_opcode), 32'(ins[7:5]));
          check("alu_a", 32'(bus.alu_a), 32'(ins[4:0]));
        end else begin
          check("fetch_req", 32'(bus.imem_req), 32'd1);
        end
      end
    end
    if (retired === 1'b1) dut_retires++;
    prev_fetch = (bus.imem_req === 1'b1) && (bus.imem_ack === 1'b1);
    if (rst === 1'b1) begin
      m_running  = 1'b0;
      m_pc       = '0;
      m_acc      = '0;
      m_zf       = 1'b0;
      m_cf       = 1'b0;
      prev_fetch = 1'b0;
    end else if (retired === 1'b1 && m_running) begin
      model_step();
    end else if (start === 1'b1 && !m_running) begin
      m_pc      = '0;
      m_running = 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
  endtask

  task automatic wait_retires(input int base, input int n, input string name);
    int k;
    k = 0;
    while ((dut_retires - base) < n && k < 200) begin
      tick(1);
      k++;
    end
    check(name, 32'(dut_retires - base), 32'(n));
  endtask

  initial begin
    int base;
    int n;
    rst = 1'b1; start = 1'b0;
    clear_mem();
    tick(2);
    rst = 1'b0;
    model_on = 1'b1;

    // Reset state
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_zf", 32'(zf), 32'd0);
    check("rst_cf", 32'(cf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_addr", 32'(bus.imem_addr), 32'd0);
    check("rst_opcode", 32'(bus.alu_opcode), 32'd0);
    tick(3);
    check("idle_no_start", 32'(busy), 32'd0);

    // LDI 1 ; ADD 1 with zero-wait ack
    mem[0] = 8'hC1; mem[1] = 8'h01;
    base = dut_retires;
    go();
    check("first_req_after_start", 32'(bus.imem_req), 32'd1);
    tick(4);
    check("t1_acc", 32'(acc), 32'h02);
    check("t1_zf", 32'(zf), 32'd0);
    check("t1_cf", 32'(cf), 32'd0);
    check("t1_retires", 32'(dut_retires - base), 32'd2);
    $display("txn prog C1,01: acc=%h zf=%b cf=%b retires=%0d", acc, zf, cf, dut_retires - base);
    do_reset();

    // LDI 5 ; SUB 5 -> zero, no borrow
    clear_mem();
    mem[0] = 8'hC5; mem[1] = 8'h25;
    go();
    tick(4);
    check("t2a_acc", 32'(acc), 32'h00);
    check("t2a_zf", 32'(zf), 32'd1);
    check("t2a_cf", 32'(cf), 32'd1);
    $display("txn prog C5,25: acc=%h zf=%b cf=%b", acc, zf, cf);
    do_reset();

    // LDI 5 ; SUB 6 -> borrow
    mem[1] = 8'h26;
    go();
    tick(4);
    check("t2b_acc", 32'(acc), 32'hFF);
    check("t2b_zf", 32'(zf), 32'd0);
    check("t2b_cf", 32'(cf), 32'd0);
    $display("txn prog C5,26: acc=%h zf=%b cf=%b", acc, zf, cf);
    do_reset();

    // Countdown loop ending in a self-loop JNZ -> HALT, then rerun
    clear_mem();
    mem[0] = 8'hC3; mem[1] = 8'h21; mem[2] = 8'hE1; mem[3] = 8'hC1; mem[4] = 8'hE4;
    for (int r = 0; r < 2; r++) begin
      base = dut_retires;
      go();
      n = 0;
      while (busy === 1'b1 && n < 300) begin
        tick(1);
        n++;
      end
      check("loop_halted", 32'(busy), 32'd0);
      check("loop_retires", 32'(dut_retires - base), 32'd9);
      check("loop_acc", 32'(acc), 32'h01);
      check("loop_pc", 32'(bus.imem_addr), 32'd4);
      tick(5);
      check("halt_hold_acc", 32'(acc), 32'h01);
      check("halt_hold_pc", 32'(bus.imem_addr), 32'd4);
      check("halt_hold_busy", 32'(busy), 32'd0);
      $display("txn loop run %0d: retires=%0d acc=%h pc=%0d", r, dut_retires - base, acc, bus.imem_addr);
    end
    do_reset();

    // Three wait cycles per fetch
    clear_mem();
    mem[0] = 8'hC1; mem[1] = 8'h01;
    ack_mode = 1;
    base = dut_retires;
    go();
    n = 0;
    while (bus.imem_req === 1'b1 && n < 20) begin
      check("wait_addr_stable", 32'(bus.imem_addr), 32'd0);
      check("wait_no_retire", 32'(retired), 32'd0);
      n++;
      tick(1);
    end
    check("wait_req_cycles", 32'(n), 32'd4);
    check("wait_retire_after_ack", 32'(retired), 32'd1);
    wait_retires(base, 2, "wait_retires");
    check("wait_acc", 32'(acc), 32'h02);
    check("wait_zf", 32'(zf), 32'd0);
    check("wait_cf", 32'(cf), 32'd0);
    $display("txn delayed-ack C1,01: req_cycles=%0d acc=%h", n, acc);

    // Reset while a fetch is outstanding, then a stray ack
    check("pre_rst_req", 32'(bus.imem_req), 32'd1);
    check("pre_rst_addr", 32'(bus.imem_addr), 32'd2);
    do_reset();
    check("post_rst_req", 32'(bus.imem_req), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_acc", 32'(acc), 32'd0);
    check("post_rst_zf", 32'(zf), 32'd0);
    check("post_rst_cf", 32'(cf), 32'd0);
    check("post_rst_addr", 32'(bus.imem_addr), 32'd0);
    check("post_rst_retired", 32'(retired), 32'd0);
    ack_mode = 2;
    force_ack = 1'b1;
    tick(3);
    check("stray_ack_busy", 32'(busy), 32'd0);
    check("stray_ack_req", 32'(bus.imem_req), 32'd0);
    force_ack = 1'b0;
    ack_mode = 0;
    $display("txn reset mid-fetch: busy=%b req=%b acc=%h", busy, bus.imem_req, acc);

    // PC wrap 31 -> 0 and ignored start mid-run
    do_reset();
    clear_mem();
    mem[0] = 8'hFF; mem[31] = 8'h01;
    go();
    n = 0;
    while (!(retired === 1'b1 && bus.imem_addr == 5'd31) && n < 50) begin
      tick(1);
      n++;
    end
    check("wrap_exec31", 32'(retired), 32'd1);
    tick(1);
    check("wrap_req", 32'(bus.imem_req), 32'd1);
    check("wrap_addr0", 32'(bus.imem_addr), 32'd0);
    check("wrap_acc", 32'(acc), 32'h01);
    n = 0;
    while (!(bus.imem_req === 1'b1 && bus.imem_addr == 5'd31) && n < 50) begin
      tick(1);
      n++;
    end
    go();
    check("midrun_start_exec", 32'(retired), 32'd1);
    check("midrun_start_addr", 32'(bus.imem_addr), 32'd31);
    tick(10);
    check("wrap_still_busy", 32'(busy), 32'd1);
    $display("txn wrap: acc=%h pc=%0d busy=%b", acc, bus.imem_addr, busy);
    do_reset();
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
